// File: rtl/cpec_bitstream_packer_pkg.sv
// Shared CPEC codec parameters and the packer state encoding.
package cpec_bitstream_packer_pkg;

  localparam int unsigned CPEC_CODE_W = 40;
  localparam int unsigned CPEC_SIZE_W = 6;
  localparam int unsigned CPEC_OUT_W  = 16;
  localparam int unsigned CPEC_ACC_W  = 64;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } cpec_pack_state_t;

endpackage

// File: rtl/cpec_bitstream_packer.sv
// Packs variable-length right-justified codes MSB-first into OUT_W-bit words,
// with a flush that zero-pads and drains the final partial word.
module cpec_bitstream_packer
  import cpec_bitstream_packer_pkg::*;
#(
  parameter int unsigned CODE_W = CPEC_CODE_W,
  parameter int unsigned SIZE_W = CPEC_SIZE_W,
  parameter int unsigned OUT_W  = CPEC_OUT_W,
  parameter int unsigned ACC_W  = CPEC_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [SIZE_W-1:0] in_size,
  input  logic              flush_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              flush_done,
  output logic [15:0]       word_count,
  output logic              size_err
);

  localparam int unsigned FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] L_OUT_W     = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] L_ACC_W     = FILL_W'(ACC_W);
  localparam logic [FILL_W-1:0] L_READY_MAX = FILL_W'(ACC_W - CODE_W);

  cpec_pack_state_t   r_state, w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [FILL_W-1:0]  r_fill;
  logic [15:0]        r_word_count;
  logic               r_size_err;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_legal;
  logic               w_take;
  logic [FILL_W-1:0]  w_size;
  logic [FILL_W-1:0]  w_fill_base;
  logic [FILL_W-1:0]  w_fill_next;
  logic [ACC_W-1:0]   w_mask;
  logic [ACC_W-1:0]   w_code_ext;
  logic [ACC_W-1:0]   w_acc_shift;
  logic [ACC_W-1:0]   w_acc_next;

  always_comb begin
    w_in_ready  = (r_state == ST_RUN) && (r_fill <= L_READY_MAX);
    w_out_valid = (r_fill >= L_OUT_W) ||
                  ((r_state == ST_FLUSH) && (r_fill != '0));
    w_in_hs     = in_valid & w_in_ready;
    w_out_hs    = w_out_valid & out_ready;
    w_legal     = (32'(in_size) <= 32'(CODE_W));
    w_take      = w_in_hs & w_legal;
    w_size      = w_take ? FILL_W'(in_size) : '0;

    // A padded final word only holds the remaining fill bits, so clamp at zero.
    w_fill_base = r_fill;
    if (w_out_hs) begin
      w_fill_base = (r_fill >= L_OUT_W) ? (r_fill - L_OUT_W) : '0;
    end
    w_fill_next = w_fill_base + w_size;

    w_mask      = ~({ACC_W{1'b1}} << w_size);
    w_code_ext  = ACC_W'(in_code) & w_mask;
    w_acc_shift = w_out_hs ? (r_acc << OUT_W) : r_acc;
    // MSB-align the code first, then drop it directly below the surviving fill.
    w_acc_next  = w_acc_shift | ((w_code_ext << (L_ACC_W - w_size)) >> w_fill_base);
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_RUN:   if (flush_req) w_state_next = ST_FLUSH;
      ST_FLUSH: if (w_fill_next == '0) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_acc        <= '0;
      r_fill       <= '0;
      r_word_count <= '0;
      r_size_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_fill  <= w_fill_next;
      if (w_out_hs) begin
        r_word_count <= r_word_count + 16'd1;
      end
      if (w_in_hs && !w_legal) begin
        r_size_err <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_data   = r_acc[ACC_W-1 -: OUT_W];
  assign flush_done = (r_state == ST_DONE);
  assign word_count = r_word_count;
  assign size_err   = r_size_err;

endmodule

// File: tb/tb_cpec_bitstream_packer.sv
// Directed bench for cpec_bitstream_packer with hand-computed expectations.
module tb_cpec_bitstream_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_code;
  logic [5:0]  in_size;
  logic        flush_req;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flush_done;
  logic [15:0] word_count;
  logic        size_err;

  int unsigned n_checks;
  int unsigned n_fails;

  cpec_bitstream_packer #(
    .CODE_W(40),
    .SIZE_W(6),
    .OUT_W (16),
    .ACC_W (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_size   (in_size),
    .flush_req (flush_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush_done(flush_done),
    .word_count(word_count),
    .size_err  (size_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    in_size   = '0;
    flush_req = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    chk("rst_out_valid",  {63'd0, out_valid},  64'd0);
    chk("rst_in_ready",   {63'd0, in_ready},   64'd1);
    chk("rst_word_count", {48'd0, word_count}, 64'd0);
    chk("rst_size_err",   {63'd0, size_err},   64'd0);
    chk("rst_out_data",   {48'd0, out_data},   64'd0);
    chk("rst_flush_done", {63'd0, flush_done}, 64'd0);
    rst_n = 1'b1;
    step();

    // Single full-width code
    in_valid = 1'b1; in_code = 40'hABCD; in_size = 6'd16; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("w16_valid", {63'd0, out_valid}, 64'd1);
    chk("w16_data",  {48'd0, out_data},  64'hABCD);
    step();
    chk("w16_count", {48'd0, word_count}, 64'd1);
    chk("w16_fill",  64'(dut.r_fill),     64'd0);
    chk("w16_idle",  {63'd0, out_valid},  64'd0);

    // Two 12-bit codes then flush
    in_valid = 1'b1; in_code = 40'h12ABC; in_size = 6'd12;
    step();
    chk("f_fill12", 64'(dut.r_fill),    64'd12);
    chk("f_nv12",   {63'd0, out_valid}, 64'd0);
    in_code = 40'hDEF; in_size = 6'd12;
    step();
    in_valid = 1'b0;
    chk("f_w1_valid", {63'd0, out_valid}, 64'd1);
    chk("f_w1_data",  {48'd0, out_data},  64'hABCD);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("f_w2_valid", {63'd0, out_valid},  64'd1);
    chk("f_w2_data",  {48'd0, out_data},   64'hEF00);
    chk("f_in_rdy0",  {63'd0, in_ready},   64'd0);
    chk("f_nodone",   {63'd0, flush_done}, 64'd0);
    step();
    chk("f_done",     {63'd0, flush_done}, 64'd1);
    chk("f_fill0",    64'(dut.r_fill),     64'd0);
    chk("f_count",    {48'd0, word_count}, 64'd3);
    step();
    chk("f_done_end", {63'd0, flush_done}, 64'd0);
    chk("f_run_rdy",  {63'd0, in_ready},   64'd1);

    // Backpressure with 40-bit codes
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 40'h12_3456_789A; in_size = 6'd40;
    step();
    chk("bp_fill40",  64'(dut.r_fill),    64'd40);
    chk("bp_rdy_low", {63'd0, in_ready},  64'd0);
    chk("bp_data",    {48'd0, out_data},  64'h1234);
    step();
    step();
    chk("bp_hold_data", {48'd0, out_data},  64'h1234);
    chk("bp_hold_vld",  {63'd0, out_valid}, 64'd1);
    chk("bp_hold_fill", 64'(dut.r_fill),    64'd40);
    out_ready = 1'b1;
    step();
    chk("bp_fill24",  64'(dut.r_fill),   64'd24);
    chk("bp_rdy_back", {63'd0, in_ready}, 64'd1);
    chk("bp_data2",   {48'd0, out_data}, 64'h5678);
    // Simultaneous accept and output handshake at fill 24
    step();
    in_valid = 1'b0;
    chk("sim_fill48", 64'(dut.r_fill),   64'd48);
    chk("sim_data",   {48'd0, out_data}, 64'h9A12);
    chk("sim_rdy0",   {63'd0, in_ready}, 64'd0);
    step();
    chk("dr_data1", {48'd0, out_data}, 64'h3456);
    step();
    chk("dr_data2", {48'd0, out_data}, 64'h789A);
    step();
    chk("dr_empty", {63'd0, out_valid},  64'd0);
    chk("dr_count", {48'd0, word_count}, 64'd8);

    // Zero-size code and illegal size
    in_valid = 1'b1; in_code = 40'hFF_FFFF_FFFF; in_size = 6'd0;
    step();
    chk("z_fill", 64'(dut.r_fill),   64'd0);
    chk("z_err",  {63'd0, size_err}, 64'd0);
    in_size = 6'd45;
    step();
    chk("err_set",  {63'd0, size_err}, 64'd1);
    chk("err_fill", 64'(dut.r_fill),   64'd0);
    in_code = 40'hA5; in_size = 6'd8; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("err_sticky", {63'd0, size_err}, 64'd1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("pad_valid", {63'd0, out_valid}, 64'd1);
    chk("pad_data",  {48'd0, out_data},  64'hA500);
    step();

    // Asynchronous reset in the middle of a flush
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {63'd0, out_valid},  64'd0);
    chk("ar_rdy",   {63'd0, in_ready},   64'd1);
    chk("ar_fill",  64'(dut.r_fill),     64'd0);
    chk("ar_err",   {63'd0, size_err},   64'd0);
    chk("ar_count", {48'd0, word_count}, 64'd0);
    chk("ar_data",  {48'd0, out_data},   64'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ar_no_done", {63'd0, flush_done}, 64'd0);
      chk("ar_run",     {63'd0, in_ready},   64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
